seq_divider_ctrl: RTL and testbench

Sequential signed 32-bit divider controller that time-multiplexes a single instance of the team's 32-bit `subtract` unit (A − B, with `isNotEqual`, `isLessThan`, `overflow`) across operand negation, 32 restoring-division iterations and result sign fix-up. It sits beside the ALU in the multiply/divide path. It accepts one operation per start pulse and reports completion with a one-cycle ready pulse plus a sticky exception flag.

---
 rtl/seq_divider_ctrl_if.sv | 32 +++
 rtl/seq_divider_ctrl.sv | 176 +++++++++++++++++
 tb/tb_seq_divider_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_ctrl_if.sv
// rtl/seq_divider_ctrl_if.sv - start/operand/result bundle for seq_divider_ctrl
//
// Purpose: groups the divider's request and result signals.
// Ports (master = requester, slave = divider):
//   ctrl_DIV        start pulse, sampled only while the divider is idle
//   data_operandA   dividend, two's complement
//   data_operandB   divisor, two's complement
//   quotient        signed quotient, held until the next accepted start
//   remainder       signed remainder, held until the next accepted start
//   data_resultRDY  one-cycle pulse when results are valid
//   data_exception  divide-by-zero or overflow, valid with ready
//   busy            high while an operation is in flight
interface seq_divider_ctrl_if;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        data_resultRDY;
  logic        data_exception;
  logic        busy;

  modport master (
    output ctrl_DIV, data_operandA, data_operandB,
    input  quotient, remainder, data_resultRDY, data_exception, busy
  );

  modport slave (
    input  ctrl_DIV, data_operandA, data_operandB,
    output quotient, remainder, data_resultRDY, data_exception, busy
  );
endinterface

// File: rtl/seq_divider_ctrl.sv
// rtl/seq_divider_ctrl.sv - sequential signed 32-bit divider sharing one subtractor
//
// Purpose: signed truncating division in 37 cycles using a single subtract
//          unit for operand negation, 32 restoring iterations and sign fix-up.
// Ports:
//   clock   rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     seq_divider_ctrl_if.slave (start, operands, results, status)
module seq_divider_ctrl (
  input  logic                clock,
  input  logic                resetn,
  seq_divider_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    NEG_A = 3'd1,
    NEG_B = 3'd2,
    ITER  = 3'd3,
    FIX_Q = 3'd4,
    FIX_R = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t      state, state_next;
  logic [31:0] a_reg;      // dividend, replaced by its magnitude in NEG_A
  logic [31:0] b_reg;      // divisor, replaced by its magnitude in NEG_B
  logic [31:0] r_reg;
  logic [31:0] q_reg;
  logic [4:0]  cnt;
  logic        sign_q;
  logic        sign_r;
  logic [31:0] quotient_q;
  logic [31:0] remainder_q;
  logic        exc_q;

  logic [31:0] sub_a, sub_b, sub_diff;
  logic        sub_ne, sub_ovf, sub_lt_unused;
  logic [31:0] t_val;
  logic        borrow;

  subtract u_sub (
    .data_operandA (sub_a),
    .data_operandB (sub_b),
    .data_result   (sub_diff),
    .isNotEqual    (sub_ne),
    .isLessThan    (sub_lt_unused),
    .overflow      (sub_ovf)
  );

  // Partial remainder shifted left with the next dividend bit. R < D <= 2^31
  // keeps this within 32 bits, so R[31] is never needed here.
  assign t_val = {r_reg[30:0], q_reg[31]};

  // Unsigned T < D: when the MSBs differ the larger value is the one with
  // MSB set; otherwise the 32-bit difference sign is exact.
  assign borrow = (t_val[31] ^ b_reg[31]) ? b_reg[31] : sub_diff[31];

  // Subtractor operand steering; in IDLE it computes 0 - divisor so that
  // isNotEqual doubles as the divide-by-zero test.
  always_comb begin
    sub_a = 32'd0;
    sub_b = 32'd0;
    case (state)
      IDLE:    sub_b = bus.data_operandB;
      NEG_A:   sub_b = a_reg;
      NEG_B:   sub_b = b_reg;
      ITER: begin
        sub_a = t_val;
        sub_b = b_reg;
      end
      FIX_Q:   sub_b = q_reg;
      FIX_R:   sub_b = r_reg;
      default: sub_b = 32'd0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.ctrl_DIV) state_next = sub_ne ? NEG_A : DONE;
      NEG_A:   state_next = NEG_B;
      NEG_B:   state_next = ITER;
      ITER:    if (cnt == 5'd31) state_next = FIX_Q;
      FIX_Q:   state_next = FIX_R;
      FIX_R:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      a_reg       <= 32'd0;
      b_reg       <= 32'd0;
      r_reg       <= 32'd0;
      q_reg       <= 32'd0;
      cnt         <= 5'd0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      quotient_q  <= 32'd0;
      remainder_q <= 32'd0;
      exc_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ctrl_DIV) begin
            a_reg  <= bus.data_operandA;
            b_reg  <= bus.data_operandB;
            sign_q <= bus.data_operandA[31] ^ bus.data_operandB[31];
            sign_r <= bus.data_operandA[31];
            exc_q  <= 1'b0;
            if (!sub_ne) begin
              quotient_q  <= 32'd0;
              remainder_q <= bus.data_operandA;
              exc_q       <= 1'b1;
            end
          end
        end
        NEG_A: if (a_reg[31]) a_reg <= sub_diff;
        NEG_B: begin
          if (b_reg[31]) b_reg <= sub_diff;
          r_reg <= 32'd0;
          q_reg <= a_reg;
          cnt   <= 5'd0;
        end
        ITER: begin
          if (borrow) begin
            r_reg <= t_val;
            q_reg <= {q_reg[30:0], 1'b0};
          end else begin
            r_reg <= sub_diff;
            q_reg <= {q_reg[30:0], 1'b1};
          end
          cnt <= cnt + 5'd1;
        end
        FIX_Q: begin
          quotient_q <= sign_q ? sub_diff : q_reg;
          // A magnitude of 2^31 is only representable as a negative result;
          // it arises solely from 0x80000000 / -1.
          exc_q      <= sub_ovf & ~sign_q;
        end
        FIX_R: remainder_q <= sign_r ? sub_diff : r_reg;
        default: ;
      endcase
    end
  end

  assign bus.quotient       = quotient_q;
  assign bus.remainder      = remainder_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = (state == DONE);
  assign bus.busy           = (state != IDLE);

endmodule

// Shared 32-bit subtractor: A - B with equality, signed less-than and overflow.
module subtract (
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        isNotEqual,
  output logic        isLessThan,
  output logic        overflow
);
  assign data_result = data_operandA - data_operandB;
  assign overflow    = (data_operandA[31] != data_operandB[31]) &&
                       (data_result[31] != data_operandA[31]);
  assign isNotEqual  = |data_result;
  assign isLessThan  = data_result[31] ^ overflow;
endmodule

// File: tb/tb_seq_divider_ctrl.sv
// tb/tb_seq_divider_ctrl.sv - directed self-checking bench for seq_divider_ctrl
module tb_seq_divider_ctrl;

  logic clock;
  logic resetn;
  int   checks;
  int   passed;

  seq_divider_ctrl_if bus ();

  seq_divider_ctrl dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Present operands and a start pulse so it is sampled on the next rising edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_DIV      = 1'b1;
    @(posedge clock);
    #1 bus.ctrl_DIV = 1'b0;
  endtask

  // Counts cycles from the start edge until ready is seen (bounded).
  task automatic wait_ready(output int cyc, output int busy_cyc);
    cyc      = 0;
    busy_cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
      if (bus.busy) busy_cyc++;
    end while (!bus.data_resultRDY && cyc < 100);
  endtask

  task automatic test_reset();
    resetn            = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = 32'd0;
    bus.data_operandB = 32'd0;
    repeat (3) @(negedge clock);
    checks++; if (bus.quotient !== 32'd0) $display("FAIL reset_q: got %h want 0", bus.quotient); else passed++;
    checks++; if (bus.remainder !== 32'd0) $display("FAIL reset_r: got %h want 0", bus.remainder); else passed++;
    checks++; if ({bus.busy, bus.data_resultRDY, bus.data_exception} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {bus.busy, bus.data_resultRDY, bus.data_exception}); else passed++;
    resetn = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic();
    int cyc, bcyc;
    start_op(32'd100, 32'd7);
    wait_ready(cyc, bcyc);
    checks++; if (cyc !== 37) $display("FAIL basic_latency: got %0d want 37", cyc); else passed++;
    checks++; if (bcyc !== 37) $display("FAIL basic_busy: got %0d want 37", bcyc); else passed++;
    checks++; if (bus.quotient !== 32'd14) $display("FAIL basic_q: got %h want %h", bus.quotient, 32'd14); else passed++;
    checks++; if (bus.remainder !== 32'd2) $display("FAIL basic_r: got %h want %h", bus.remainder, 32'd2); else passed++;
    checks++; if (bus.data_exception !== 1'b0) $display("FAIL basic_exc: got %b want 0", bus.data_exception); else passed++;
    @(negedge clock);
    checks++; if ({bus.busy, bus.data_resultRDY} !== 2'b00)
      $display("FAIL basic_after_done: got %b want 00", {bus.busy, bus.data_resultRDY}); else passed++;
  endtask

  task automatic test_signs();
    int cyc, bcyc;
    start_op(-32'sd100, 32'd7);
    wait_ready(cyc, bcyc);
    checks++; if (bus.quotient !== 32'hFFFFFFF2) $display("FAIL negdiv_q: got %h want fffffff2", bus.quotient); else passed++;
    checks++; if (bus.remainder !== 32'hFFFFFFFE) $display("FAIL negdiv_r: got %h want fffffffe", bus.remainder); else passed++;
    start_op(32'd100, -32'sd7);
    wait_ready(cyc, bcyc);
    checks++; if (bus.quotient !== 32'hFFFFFFF2) $display("FAIL negdsr_q: got %h want fffffff2", bus.quotient); else passed++;
    checks++; if (bus.remainder !== 32'd2) $display("FAIL negdsr_r: got %h want 2", bus.remainder); else passed++;
    checks++; if (bus.data_exception !== 1'b0) $display("FAIL negdsr_exc: got %b want 0", bus.data_exception); else passed++;
  endtask

  task automatic test_overflow();
    int cyc, bcyc;
    start_op(32'h80000000, 32'hFFFFFFFF);
    wait_ready(cyc, bcyc);
    checks++; if (bus.quotient !== 32'h80000000) $display("FAIL ovf_q: got %h want 80000000", bus.quotient); else passed++;
    checks++; if (bus.remainder !== 32'd0) $display("FAIL ovf_r: got %h want 0", bus.remainder); else passed++;
    checks++; if (bus.data_exception !== 1'b1) $display("FAIL ovf_exc: got %b want 1", bus.data_exception); else passed++;
    start_op(32'hFFFFFFFF, 32'h80000000);
    wait_ready(cyc, bcyc);
    checks++; if (bus.quotient !== 32'd0) $display("FAIL min_dsr_q: got %h want 0", bus.quotient); else passed++;
    checks++; if (bus.remainder !== 32'hFFFFFFFF) $display("FAIL min_dsr_r: got %h want ffffffff", bus.remainder); else passed++;
    checks++; if (bus.data_exception !== 1'b0) $display("FAIL min_dsr_exc: got %b want 0", bus.data_exception); else passed++;
  endtask

  task automatic test_div_zero();
    int cyc, bcyc;
    start_op(32'd5, 32'd0);
    wait_ready(cyc, bcyc);
    checks++; if (cyc !== 1) $display("FAIL dz_latency: got %0d want 1", cyc); else passed++;
    checks++; if (bus.data_exception !== 1'b1) $display("FAIL dz_exc: got %b want 1", bus.data_exception); else passed++;
    checks++; if (bus.quotient !== 32'd0) $display("FAIL dz_q: got %h want 0", bus.quotient); else passed++;
    checks++; if (bus.remainder !== 32'd5) $display("FAIL dz_r: got %h want 5", bus.remainder); else passed++;
    // Back-to-back: the next start lands on the first IDLE cycle after DONE.
    start_op(32'd9, 32'd3);
    @(negedge clock);
    checks++; if ({bus.busy, bus.data_exception} !== 2'b10)
      $display("FAIL b2b_start: got busy,exc=%b want 10", {bus.busy, bus.data_exception}); else passed++;
    wait_ready(cyc, bcyc);
    checks++; if (cyc !== 36) $display("FAIL b2b_latency: got %0d more cycles want 36", cyc); else passed++;
    checks++; if (bus.quotient !== 32'd3) $display("FAIL b2b_q: got %h want 3", bus.quotient); else passed++;
    checks++; if (bus.remainder !== 32'd0) $display("FAIL b2b_r: got %h want 0", bus.remainder); else passed++;
  endtask

  task automatic test_ignore_start();
    int cyc;
    int ready_cnt;
    int first_ready;
    start_op(32'd100, 32'd7);
    cyc         = 0;
    ready_cnt   = 0;
    first_ready = 0;
    repeat (80) begin
      @(negedge clock);
      cyc++;
      if (cyc == 10) begin
        bus.data_operandA = 32'd50;
        bus.data_operandB = 32'd5;
        bus.ctrl_DIV      = 1'b1;
      end else begin
        bus.ctrl_DIV = 1'b0;
      end
      if (bus.data_resultRDY) begin
        ready_cnt++;
        if (first_ready == 0) first_ready = cyc;
      end
    end
    checks++; if (ready_cnt !== 1) $display("FAIL ign_ready_count: got %0d want 1", ready_cnt); else passed++;
    checks++; if (first_ready !== 37) $display("FAIL ign_latency: got %0d want 37", first_ready); else passed++;
    checks++; if (bus.quotient !== 32'd14) $display("FAIL ign_q: got %h want %h", bus.quotient, 32'd14); else passed++;
    checks++; if (bus.remainder !== 32'd2) $display("FAIL ign_r: got %h want 2", bus.remainder); else passed++;
  endtask

  task automatic test_reset_mid();
    int cyc, bcyc;
    int seen_bad;
    start_op(32'd1000, 32'd3);
    repeat (15) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    checks++; if ({bus.quotient, bus.remainder} !== 64'd0)
      $display("FAIL rst_mid_data: got q=%h r=%h want 0", bus.quotient, bus.remainder); else passed++;
    checks++; if ({bus.busy, bus.data_resultRDY, bus.data_exception} !== 3'b000)
      $display("FAIL rst_mid_flags: got %b want 000", {bus.busy, bus.data_resultRDY, bus.data_exception}); else passed++;
    seen_bad = 0;
    repeat (3) begin
      @(negedge clock);
      if (bus.data_resultRDY || bus.busy) seen_bad++;
    end
    resetn = 1'b1;
    repeat (40) begin
      @(negedge clock);
      if (bus.data_resultRDY || bus.busy) seen_bad++;
    end
    checks++; if (seen_bad !== 0) $display("FAIL rst_mid_no_ready: got %0d active cycles want 0", seen_bad); else passed++;
    start_op(32'hFFFFFFFF, 32'h00000001);
    wait_ready(cyc, bcyc);
    checks++; if (cyc !== 37) $display("FAIL rst_after_latency: got %0d want 37", cyc); else passed++;
    checks++; if (bus.quotient !== 32'hFFFFFFFF) $display("FAIL rst_after_q: got %h want ffffffff", bus.quotient); else passed++;
    checks++; if (bus.remainder !== 32'd0) $display("FAIL rst_after_r: got %h want 0", bus.remainder); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_basic();
    test_signs();
    test_overflow();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
